// File: rtl/handshake_pkg.sv
// Shared types for the handshake_output valid/ready source.
package handshake_pkg;

    // Default data width of the produced stream.
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Default value type used with the default width.
    typedef logic [DEFAULT_DATA_WIDTH-1:0] value_t;

    // Source state: IDLE holds o_valid low after reset, VALID presents a word.
    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_e;

endpackage : handshake_pkg

// File: rtl/handshake_counter.sv
// Value register for the handshake source. It starts at INIT_VALUE and
// advances by STEP (modulo 2**DATA_WIDTH) whenever advance_i is high.
// count_o is the value currently on offer, and count_next_o is the value
// that will follow it.
module handshake_counter
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int INIT_VALUE = 1,
    parameter int STEP       = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  advance_i,
    output logic [DATA_WIDTH-1:0] count_o,
    output logic [DATA_WIDTH-1:0] count_next_o
);

    localparam logic [DATA_WIDTH-1:0] INIT_C = DATA_WIDTH'(INIT_VALUE);
    localparam logic [DATA_WIDTH-1:0] STEP_C = DATA_WIDTH'(STEP);

    logic [DATA_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] count_d;
    logic [DATA_WIDTH-1:0] count_inc;

    // Wrap-around is implicit: the sum is truncated to DATA_WIDTH bits.
    assign count_inc = count_q + STEP_C;

    // Next-state selection: step forward only when a word is accepted.
    always_comb begin
        // NOTE: give every always_comb output a default first so that no
        // path leaves it unassigned, which would infer a latch.
        count_d = count_q;
        if (advance_i) begin
            count_d = count_inc;
        end
    end

    // Value register; reset loads the first value of the sequence.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // flop samples the values from before the edge. The reset is sampled
        // on the clock edge, so it appears only inside the clocked branch.
        if (reset) begin
            count_q <= INIT_C;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_inc;

endmodule : handshake_counter

// File: rtl/handshake_output.sv
// Valid/ready producer that emits INIT_VALUE, INIT_VALUE+STEP, ... with one
// word per accepted transfer. Both outputs come straight from flops, so
// i_ready has no combinational path to o_value or o_valid.
module handshake_output
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int INIT_VALUE = 1,
    parameter int STEP       = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] o_value,
    output logic                  o_valid,
    input  logic                  i_ready
);

    state_e                state_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] value_q;

    logic                  transfer;
    logic [DATA_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0] count_next;

    // A word moves on every edge where it is both offered and accepted.
    // i_ready has no effect while nothing is offered.
    assign transfer = valid_q && i_ready;

    handshake_counter #(
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_VALUE (INIT_VALUE),
        .STEP       (STEP)
    ) u_counter (
        .clock        (clock),
        .reset        (reset),
        .advance_i    (transfer),
        .count_o      (count),
        .count_next_o (count_next)
    );

    // State machine with registered outputs. IDLE offers the first value,
    // and VALID replaces the word only when it has been accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            value_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= VALID;
                    valid_q <= 1'b1;
                    value_q <= count;
                end
                VALID: begin
                    state_q <= VALID;
                    valid_q <= 1'b1;
                    if (transfer) begin
                        value_q <= count_next;
                    end
                end
            endcase
        end
    end

    assign o_value = value_q;
    assign o_valid = valid_q;

endmodule : handshake_output

// File: tb/tb_handshake_output.sv
// Self-checking bench for handshake_output. It runs a default instance and an
// instance with DATA_WIDTH=4, INIT_VALUE=3, STEP=5. The bench predicts each
// output from a count of accepted transfers: value = INIT + k*STEP mod 2**W.
module tb_handshake_output;
    import handshake_pkg::*;

    logic       clock;
    logic       reset;
    logic       ready_a;
    logic       ready_b;
    value_t     value_a;
    logic       valid_a;
    logic [3:0] value_b;
    logic       valid_b;

    int checks;
    int errors;

    // Reference model: validity flag and number of accepted words per instance.
    bit exp_valid_a;
    bit exp_valid_b;
    int acc_a;
    int acc_b;

    handshake_output u_dut_a (
        .clock   (clock),
        .reset   (reset),
        .o_value (value_a),
        .o_valid (valid_a),
        .i_ready (ready_a)
    );

    handshake_output #(
        .DATA_WIDTH (4),
        .INIT_VALUE (3),
        .STEP       (5)
    ) u_dut_b (
        .clock   (clock),
        .reset   (reset),
        .o_value (value_b),
        .o_valid (valid_b),
        .i_ready (ready_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, and check at the
    // following falling edge.
    task automatic cycle(input bit rst, input bit rdy_a, input bit rdy_b);
        reset   = rst;
        ready_a = rdy_a;
        ready_b = rdy_b;
        @(posedge clock);
        if (rst) begin
            exp_valid_a = 1'b0;
            exp_valid_b = 1'b0;
            acc_a       = 0;
            acc_b       = 0;
        end else begin
            if (exp_valid_a && rdy_a) acc_a++;
            if (exp_valid_b && rdy_b) acc_b++;
            exp_valid_a = 1'b1;
            exp_valid_b = 1'b1;
        end
        @(negedge clock);
        check("valid_a", int'(valid_a), int'(exp_valid_a));
        check("value_a", int'(value_a), exp_valid_a ? (1 + acc_a) % 256 : 0);
        check("valid_b", int'(valid_b), int'(exp_valid_b));
        check("value_b", int'(value_b), exp_valid_b ? (3 + 5 * acc_b) % 16 : 0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        ready_a = 1'b0;
        ready_b = 1'b0;

        // Reset held for 10 clocks with random ready, which must be ignored.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'($urandom), 1'($urandom));

        // Release: the first valid word appears one clock later.
        cycle(1'b0, 1'b0, 1'b0);
        check("startup_value", int'(value_a), 1);

        // 100 single-clock ready pulses separated by random idle gaps.
        for (int p = 0; p < 100; p++) begin
            int gap;
            gap = int'($urandom_range(0, 10));
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 1'($urandom));
            cycle(1'b0, 1'b1, 1'($urandom));
        end
        check("pulse_final_value", int'(value_a), 101);

        // Continuous ready for 300 clocks from a fresh start; both streams wrap.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 1'b1);
        check("wrap_final_value", int'(value_a), 301 % 256);

        // Stall while value 5 is offered.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            check("stall_value", int'(value_a), 5);
        end

        // Reset after value 42 has been accepted.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 42; i++) cycle(1'b0, 1'b1, 1'($urandom));
        check("pre_reset_value", int'(value_a), 43);
        cycle(1'b1, 1'b1, 1'b1);
        check("midreset_valid", int'(valid_a), 0);
        cycle(1'b0, 1'b1, 1'b1);
        check("restart_value", int'(value_a), 1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'($urandom), 1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_handshake_output
